// File: rtl/amp_i2c_target.sv
// I2C target receiver: the first byte after the address sets a register pointer, and each later byte becomes a one-clk write strobe.
// Define AMP_I2C_TARGET_READ_EN to also serve controller reads from reg_rd_data.
module amp_i2c_target #(
    parameter logic [6:0] I2C_ADDR    = 7'h20,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic [7:0] reg_rd_addr,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] IGNORE   = 3'd2;
    localparam logic [2:0] ACK      = 3'd3;
    localparam logic [2:0] REG      = 3'd4;
    localparam logic [2:0] DATA     = 3'd5;
`ifdef AMP_I2C_TARGET_READ_EN
    localparam logic [2:0] RD_SHIFT = 3'd6;
    localparam logic [2:0] RD_ACK   = 3'd7;
`endif

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    logic [2:0] state_q, state_d;
    logic [2:0] ack_nxt_q, ack_nxt_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] ptr_q, ptr_d;
    logic       sda_oe_q, sda_oe_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;

    // Sync flops reset to the idle-bus level so reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    always_comb begin
        state_d   = state_q;
        ack_nxt_d = ack_nxt_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (wr_en_q) begin
            ptr_d = ptr_q + 8'd1;
        end
        if (start_det) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, REG, DATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shreg_d = {shreg_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d    = 4'd0;
                        sda_oe_d = 1'b1;
                        state_d  = ACK;
                        if (state_q == ADDR) begin
                            if (shreg_q[7:1] != I2C_ADDR) begin
                                sda_oe_d = 1'b0;
                                state_d  = IGNORE;
                            end else if (!shreg_q[0]) begin
                                ack_nxt_d = REG;
`ifdef AMP_I2C_TARGET_READ_EN
                            end else begin
                                ack_nxt_d = RD_SHIFT;
                            end
`else
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = IGNORE;
                            end
`endif
                        end else if (state_q == REG) begin
                            ptr_d     = shreg_q;
                            ack_nxt_d = DATA;
                        end else begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = shreg_q;
                            ack_nxt_d = DATA;
                        end
                    end
                end
                ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ack_nxt_q;
                        cnt_d    = 4'd0;
`ifdef AMP_I2C_TARGET_READ_EN
                        // Releasing the ACK and driving the read MSB share this falling edge.
                        if (ack_nxt_q == RD_SHIFT) begin
                            shreg_d  = reg_rd_data;
                            sda_oe_d = ~reg_rd_data[7];
                            cnt_d    = 4'd1;
                        end
`endif
                    end
                end
`ifdef AMP_I2C_TARGET_READ_EN
                RD_SHIFT: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = RD_ACK;
                        end else begin
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            sda_oe_d = ~shreg_q[6];
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_d     = ptr_q + 8'd1;
                            ack_nxt_d = RD_SHIFT;
                            state_d   = ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
`endif
                IDLE, IGNORE: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q   <= IDLE;
            ack_nxt_q <= IDLE;
            cnt_q     <= 4'd0;
            shreg_q   <= 8'd0;
            ptr_q     <= 8'd0;
            sda_oe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            ack_nxt_q <= ack_nxt_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifndef AMP_I2C_TARGET_READ_EN
    logic unused_rd_data;
    assign unused_rd_data = ^reg_rd_data;
`endif

    assign sda_oe      = sda_oe_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign reg_rd_addr = ptr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_amp_i2c_target.sv
// Directed bench for amp_i2c_target: a byte-level bus model predicts ACKs, write strobes, read bytes and the pointer.
`timescale 1ns/1ps
module tb_amp_i2c_target;
    localparam int SYNC = 2;
    localparam int Q    = 5;
`ifdef AMP_I2C_TARGET_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       scl_ctrl = 1'b1;
    logic       sda_ctrl = 1'b1;
    logic       sda_bus;
    logic       sda_oe, reg_wr_en, busy;
    logic [7:0] reg_wr_addr, reg_wr_data, reg_rd_addr, reg_rd_data;
    logic [7:0] mem [256];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    bit quiet = 1'b0;
    int quiet_viol = 0;

    typedef enum {M_IDLE, M_ADDR, M_REG, M_DATA, M_RD, M_IGN} mph_t;
    typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
    mph_t       m_ph = M_IDLE;
    logic [7:0] m_ptr = 8'd0;
    wr_t        exp_q[$];
    logic       prev_strobe = 1'b0;
    logic [7:0] prev_addr = 8'd0;

    amp_i2c_target #(.I2C_ADDR(7'h20), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .resetb(resetb), .scl_in(scl_ctrl), .sda_in(sda_bus),
        .sda_oe(sda_oe), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data), .busy(busy)
    );

    assign sda_bus     = sda_ctrl & ~sda_oe;
    assign reg_rd_data = mem[reg_rd_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Strobe scoreboard, pointer post-increment and SDA-quiet monitor.
    always @(negedge clk) begin
        if (resetb) begin
            if (prev_strobe) chk("ptr_inc", int'(reg_rd_addr), int'(8'(prev_addr + 8'd1)));
            if (reg_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_strobe", int'(reg_wr_en), 0);
                end else begin
                    chk("strobe_addr", int'(reg_wr_addr), int'(exp_q[0].a));
                    chk("strobe_data", int'(reg_wr_data), int'(exp_q[0].d));
                    chk("strobe_latency", cyc - last_fall_cyc, 1 + SYNC);
                    void'(exp_q.pop_front());
                end
            end
            if (quiet && sda_oe) quiet_viol <= quiet_viol + 1;
        end
        prev_strobe <= reg_wr_en & resetb;
        prev_addr   <= reg_wr_addr;
    end

    task automatic bw(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit ack);
        wr_t w;
        ack = 1'b0;
        case (m_ph)
            M_ADDR: begin
                if (b[7:1] == 7'h20 && (!b[0] || READ_EN)) begin
                    m_ph = b[0] ? M_RD : M_REG;
                    ack  = 1'b1;
                end else begin
                    m_ph = M_IGN;
                end
            end
            M_REG: begin
                m_ptr = b;
                m_ph  = M_DATA;
                ack   = 1'b1;
            end
            M_DATA: begin
                w.a = m_ptr;
                w.d = b;
                exp_q.push_back(w);
                m_ptr = m_ptr + 8'd1;
                ack   = 1'b1;
            end
            default: ack = 1'b0;
        endcase
    endtask

    task automatic clk_bit(input logic b, output logic seen);
        sda_ctrl = b;
        bw(Q);
        scl_ctrl = 1'b1;
        bw(Q);
        seen = sda_bus;
        bw(Q);
        scl_ctrl = 1'b0;
        last_fall_cyc = cyc;
        bw(Q);
    endtask

    task automatic i2c_start();
        sda_ctrl = 1'b1;
        bw(Q);
        scl_ctrl = 1'b1;
        bw(Q);
        sda_ctrl = 1'b0;
        bw(Q);
        scl_ctrl = 1'b0;
        bw(Q);
        m_ph = M_ADDR;
    endtask

    task automatic i2c_stop();
        sda_ctrl = 1'b0;
        bw(Q);
        scl_ctrl = 1'b1;
        bw(Q);
        sda_ctrl = 1'b1;
        bw(2 * Q);
        m_ph = M_IDLE;
    endtask

    task automatic send_byte(input logic [7:0] b, input string nm);
        logic seen;
        bit   exp_ack;
        model_byte(b, exp_ack);
        for (int i = 7; i >= 0; i--) clk_bit(b[i], seen);
        clk_bit(1'b1, seen);
        chk(nm, int'(!seen), int'(exp_ack));
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        logic seen;
        for (int i = 7; i > 7 - n; i--) clk_bit(b[i], seen);
    endtask

    task automatic read_byte(input bit ctrl_ack, output logic [7:0] got);
        logic       seen;
        logic [7:0] exp_b;
        exp_b = (m_ph == M_RD) ? mem[m_ptr] : 8'hFF;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, seen);
            got[i] = seen;
        end
        clk_bit(~ctrl_ack, seen);
        chk("rd_byte", int'(got), int'(exp_b));
        if (m_ph == M_RD) begin
            if (ctrl_ack) m_ptr = m_ptr + 8'd1;
            else m_ph = M_IGN;
        end
    endtask

    task automatic end_checks();
        chk("busy_idle", int'(busy), 0);
        chk("ptr_model", int'(reg_rd_addr), int'(m_ptr));
        chk("strobes_pending", exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] g0, g1;
        int         v0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5C;
        mem[8'h10] = 8'h5A;
        mem[8'h11] = 8'hC3;

        resetb = 1'b0;
        bw(4);
        chk("rst_sda_oe", int'(sda_oe), 0);
        chk("rst_wr_en", int'(reg_wr_en), 0);
        chk("rst_wr_addr", int'(reg_wr_addr), 0);
        chk("rst_wr_data", int'(reg_wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ptr", int'(reg_rd_addr), 0);
        resetb = 1'b1;
        bw(4);

        // single write 0x40 <- 0x18
        i2c_start();
        chk("busy_after_start", int'(busy), 1);
        send_byte(8'h40, "ack_addr");
        send_byte(8'h40, "ack_reg");
        send_byte(8'h18, "ack_data");
        i2c_stop();
        end_checks();
        chk("hold_addr_40", int'(reg_wr_addr), 8'h40);
        chk("hold_data_18", int'(reg_wr_data), 8'h18);
        chk("ptr_41", int'(reg_rd_addr), 8'h41);

        // burst at 0x35
        i2c_start();
        send_byte(8'h40, "ack_addr");
        send_byte(8'h35, "ack_reg");
        send_byte(8'h08, "ack_data");
        send_byte(8'h09, "ack_data");
        i2c_stop();
        end_checks();
        chk("ptr_37", int'(reg_rd_addr), 8'h37);
        chk("hold_addr_36", int'(reg_wr_addr), 8'h36);

        // foreign address 0x21: never drive SDA
        v0 = quiet_viol;
        quiet = 1'b1;
        i2c_start();
        send_byte(8'h42, "nack_addr21");
        send_byte(8'h50, "nack_ignored");
        chk("busy_ignore", int'(busy), 1);
        i2c_stop();
        quiet = 1'b0;
        chk("sda_quiet", quiet_viol - v0, 0);
        end_checks();

        // pointer wrap
        i2c_start();
        send_byte(8'h40, "ack_addr");
        send_byte(8'hFF, "ack_reg");
        send_byte(8'hAA, "ack_data");
        send_byte(8'hBB, "ack_data");
        i2c_stop();
        end_checks();
        chk("ptr_wrap_01", int'(reg_rd_addr), 8'h01);
        chk("hold_addr_00", int'(reg_wr_addr), 8'h00);
        chk("hold_data_bb", int'(reg_wr_data), 8'hBB);

        // STOP mid-byte discards the partial byte
        i2c_start();
        send_byte(8'h40, "ack_addr");
        send_byte(8'h70, "ack_reg");
        send_byte(8'h11, "ack_data");
        send_bits(8'h22, 4);
        i2c_stop();
        end_checks();
        chk("ptr_71", int'(reg_rd_addr), 8'h71);
        chk("hold_data_11", int'(reg_wr_data), 8'h11);
        i2c_start();
        send_byte(8'h40, "ack_addr_after_abort");
        send_byte(8'h80, "ack_reg");
        send_byte(8'h44, "ack_data");
        i2c_stop();
        end_checks();
        chk("ptr_81", int'(reg_rd_addr), 8'h81);

        // register read through repeated START
        i2c_start();
        send_byte(8'h40, "ack_addr");
        send_byte(8'h10, "ack_reg");
        i2c_start();
        send_byte(8'h41, "rd_addr_ack");
        read_byte(1'b1, g0);
        read_byte(1'b0, g1);
        i2c_stop();
        end_checks();
`ifdef AMP_I2C_TARGET_READ_EN
        chk("rd_lit_5a", int'(g0), 8'h5A);
        chk("rd_lit_c3", int'(g1), 8'hC3);
        chk("ptr_11", int'(reg_rd_addr), 8'h11);
`else
        chk("rd_idle_ff", int'(g0), 8'hFF);
        chk("ptr_10", int'(reg_rd_addr), 8'h10);
`endif

        // reset mid-transaction
        i2c_start();
        send_byte(8'h40, "ack_addr");
        send_byte(8'h50, "ack_reg");
        send_bits(8'h77, 4);
        resetb = 1'b0;
        scl_ctrl = 1'b1;
        sda_ctrl = 1'b1;
        m_ptr = 8'd0;
        m_ph = M_IDLE;
        bw(3);
        resetb = 1'b1;
        bw(4);
        end_checks();
        chk("rst_mid_wr_addr", int'(reg_wr_addr), 0);
        chk("rst_mid_wr_data", int'(reg_wr_data), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
